// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents: fetch FSM state encoding, default reset PC, and the fetch-entry
// record that travels through the instruction buffer.
package ifu_pkg;

    // Widest PC the entry record can carry; narrower PCs are zero-extended.
    localparam int MAX_XLEN = 64;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // issuing a fetch request
        ST_WAIT = 2'd1,   // one request outstanding, waiting for its response
        ST_DROP = 2'd2,   // outstanding response belongs to a stale stream
        ST_HALT = 2'd3    // access fault seen, idle until redirected
    } ifu_state_e;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [31:0]         inst;
        logic                err;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_pipe_if.sv
// Bundle of the fetch unit's redirect, memory and decode-side signals.
// master: the fetch unit (drives mem_req_*, out_*).
// slave : the environment (core redirect source, instruction memory, decode).
interface ifu_pipe_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rsp_data;
    logic            mem_rsp_err;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_err;

    modport master (
        input  redirect_valid, redirect_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  out_ready,
        output mem_req_valid, mem_req_addr,
        output out_valid, out_pc, out_inst, out_err
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output out_ready,
        input  mem_req_valid, mem_req_addr,
        input  out_valid, out_pc, out_inst, out_err
    );
endinterface

// File: rtl/ifu_pipe_sync_fifo.sv
// Synchronous FIFO with flush, used as the fetch instruction buffer.
// Ports: clk/rst (sync, active-low), flush (empties the buffer next cycle),
// push/push_data, pop (ignored when empty), head_data (zero when empty),
// count (occupancy), empty.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full_s    = (count_r == FULL_CNT);
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty;
    assign count     = count_r;
    assign head_data = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end
endmodule

// File: rtl/ifu_pipe.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, buffers
// returned instructions for decode, and restarts on redirect.
// Ports: clk, rst (sync, active-low), bus (ifu_pipe_if.master):
//   redirect_valid/redirect_pc  - flush and restart fetch
//   mem_req_* / mem_rsp_*       - instruction memory request/response
//   out_*                       - head of the instruction buffer to decode
module ifu_pipe
    import ifu_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int              FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    ifu_pipe_if.master  bus
);
    localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_CNT  = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    ifu_state_e      state_r;
    ifu_state_e      next_state_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] req_pc_r;
    logic            live_r;
    logic            req_valid_s;
    logic            hs_s;
    logic            push_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_s;
    logic [CW-1:0]   count_s;
    logic            empty_s;

    assign hs_s = req_valid_s & bus.mem_req_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic. Redirect wins over everything. A response that
    // lands in the redirect cycle is discarded and also retires the
    // outstanding request, so the FSM does not wait for a second one.
    always_comb begin
        next_state_s = state_r;
        if (bus.redirect_valid) begin
            case (state_r)
                ST_REQ:  next_state_s = hs_s ? ST_DROP : ST_REQ;
                ST_WAIT: next_state_s = bus.mem_rsp_valid ? ST_REQ : ST_DROP;
                ST_DROP: next_state_s = bus.mem_rsp_valid ? ST_REQ : ST_DROP;
                ST_HALT: next_state_s = ST_REQ;
                default: next_state_s = ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_REQ:  next_state_s = hs_s ? ST_WAIT : ST_REQ;
                ST_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        next_state_s = bus.mem_rsp_err ? ST_HALT : ST_REQ;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_DROP: next_state_s = bus.mem_rsp_valid ? ST_REQ : ST_DROP;
                ST_HALT: next_state_s = ST_HALT;
                default: next_state_s = ST_REQ;
            endcase
        end
    end

    // FSM outputs: request only with buffer space; push only real responses.
    // live_r suppresses a request in the cycle following a reset edge.
    always_comb begin
        req_valid_s = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_REQ:  req_valid_s = live_r & (count_s < DEPTH_CNT);
            ST_WAIT: push_s      = bus.mem_rsp_valid & ~bus.redirect_valid;
            default: begin
                req_valid_s = 1'b0;
                push_s      = 1'b0;
            end
        endcase
    end

    // Set one cycle after reset is released; keeps mem_req_valid low while
    // reset is applied without looking at rst combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Fetch PC: restart on redirect, advance only after a good response, so
    // the address stays constant while a request waits for ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc_r <= bus.redirect_pc & ALIGN_MASK;
        end else if (push_s && !bus.mem_rsp_err) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
    end

    // PC of the outstanding request, tagged onto its response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_pc_r <= RESET_PC;
        end else if (hs_s) begin
            req_pc_r <= fetch_pc_r;
        end
    end

    // Assemble the buffer entry from the outstanding PC and the response.
    always_comb begin
        push_entry_s      = '{default: 1'b0};
        push_entry_s.pc   = MAX_XLEN'(req_pc_r);
        push_entry_s.inst = bus.mem_rsp_data;
        push_entry_s.err  = bus.mem_rsp_err;
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (bus.out_ready),
        .head_data (head_s),
        .count     (count_s),
        .empty     (empty_s)
    );

    assign bus.mem_req_valid = req_valid_s;
    assign bus.mem_req_addr  = fetch_pc_r;
    assign bus.out_valid     = ~empty_s;
    assign bus.out_pc        = XLEN'(head_s.pc);
    assign bus.out_inst      = head_s.inst;
    assign bus.out_err       = head_s.err;
endmodule

// File: tb/tb_ifu_pipe.sv
// Directed testbench for ifu_pipe: reset state, streaming fetch, buffer
// back-pressure, redirect drop, access fault halt, PC wrap, stalled ready.
module tb_ifu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ifu_pipe_if #(.XLEN(32)) bus ();

    ifu_pipe #(
        .XLEN       (32),
        .RESET_PC   (32'h8000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests        = 0;
    int          fails        = 0;
    int          hs_cnt       = 0;
    logic [31:0] last_hs_addr = 32'h0;
    bit          auto_rsp     = 1'b1;
    bit          err_en       = 1'b0;
    logic [31:0] err_addr     = 32'h0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: note a handshake, advance, then (in auto mode) answer it
    // in the following cycle like a 1-cycle-latency memory.
    task automatic clk_step();
        logic        hs;
        logic [31:0] a;
        hs = bus.mem_req_valid && bus.mem_req_ready;
        a  = bus.mem_req_addr;
        @(posedge clk);
        #1;
        if (hs && rst) begin
            hs_cnt++;
            last_hs_addr = a;
        end
        if (auto_rsp) begin
            bus.mem_rsp_valid = hs;
            bus.mem_rsp_data  = hs ? inst_of(a) : 32'h0;
            bus.mem_rsp_err   = hs && err_en && (a == err_addr);
        end
    endtask

    task automatic do_reset();
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b1;
        bus.out_ready      = 1'b1;
        bus.mem_rsp_valid  = 1'b0;
        bus.mem_rsp_data   = 32'h0;
        bus.mem_rsp_err    = 1'b0;
        auto_rsp           = 1'b1;
        err_en             = 1'b0;
        clk_step();
        clk_step();
        check("rst_req_valid", bus.mem_req_valid, 32'h0);
        check("rst_out_valid", bus.out_valid, 32'h0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_inst", bus.out_inst, 32'h0);
        rst    = 1'b1;
        hs_cnt = 0;
    endtask

    // Wait (bounded) for a head entry, check it, and consume it.
    task automatic expect_out(input string tag, input logic [31:0] pc, input logic err);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            clk_step();
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 32'h1);
        check({tag, "_pc"}, bus.out_pc, pc);
        check({tag, "_inst"}, bus.out_inst, inst_of(pc));
        check({tag, "_err"}, bus.out_err, {31'b0, err});
        clk_step();
    endtask

    initial begin
        int n;

        // Streaming fetch with 1-cycle memory and decode always ready.
        do_reset();
        clk_step();
        check("t1_req0_valid", bus.mem_req_valid, 32'h1);
        check("t1_req0_addr", bus.mem_req_addr, 32'h8000_0000);
        clk_step();
        check("t1_lat_rsp_cycle", bus.out_valid, 32'h0);
        clk_step();
        check("t1_lat_next_cycle", bus.out_valid, 32'h1);
        expect_out("t1_e0", 32'h8000_0000, 1'b0);
        expect_out("t1_e1", 32'h8000_0004, 1'b0);
        expect_out("t1_e2", 32'h8000_0008, 1'b0);

        // Decode stalled: buffer fills to 4 and requests stop.
        do_reset();
        bus.out_ready = 1'b0;
        repeat (20) clk_step();
        check("t2_hs_cnt_full", hs_cnt, 32'd4);
        check("t2_req_valid_full", bus.mem_req_valid, 32'h0);
        check("t2_addr_full", bus.mem_req_addr, 32'h8000_0010);
        check("t2_out_valid_full", bus.out_valid, 32'h1);
        bus.out_ready = 1'b1;
        expect_out("t2_e0", 32'h8000_0000, 1'b0);
        expect_out("t2_e1", 32'h8000_0004, 1'b0);
        check("t2_resume_cnt", hs_cnt, 32'd5);
        check("t2_resume_addr", last_hs_addr, 32'h8000_0010);
        expect_out("t2_e2", 32'h8000_0008, 1'b0);
        expect_out("t2_e3", 32'h8000_000C, 1'b0);
        expect_out("t2_e4", 32'h8000_0010, 1'b0);

        // Redirect while waiting: buffer flushed, late response dropped.
        do_reset();
        bus.out_ready = 1'b0;
        n = 0;
        while (hs_cnt < 3 && n < 40) begin
            clk_step();
            n++;
        end
        check("t3_third_req", hs_cnt, 32'd3);
        auto_rsp          = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        check("t3_prefill", bus.out_valid, 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        clk_step();
        bus.redirect_valid = 1'b0;
        check("t3_flushed_valid", bus.out_valid, 32'h0);
        check("t3_flushed_pc", bus.out_pc, 32'h0);
        check("t3_drop_no_req", bus.mem_req_valid, 32'h0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hDEAD_BEEF;
        clk_step();
        bus.mem_rsp_valid = 1'b0;
        check("t3_stale_not_pushed", bus.out_valid, 32'h0);
        check("t3_new_req_valid", bus.mem_req_valid, 32'h1);
        check("t3_new_req_addr", bus.mem_req_addr, 32'h8000_0100);
        auto_rsp      = 1'b1;
        bus.out_ready = 1'b1;
        expect_out("t3_e0", 32'h8000_0100, 1'b0);

        // Access fault: entry flagged, fetch halts until redirected.
        do_reset();
        err_en   = 1'b1;
        err_addr = 32'h8000_0008;
        expect_out("t4_e0", 32'h8000_0000, 1'b0);
        expect_out("t4_e1", 32'h8000_0004, 1'b0);
        expect_out("t4_e2", 32'h8000_0008, 1'b1);
        check("t4_halt_no_req", bus.mem_req_valid, 32'h0);
        repeat (4) clk_step();
        check("t4_halt_hs_cnt", hs_cnt, 32'd3);
        check("t4_halt_still", bus.mem_req_valid, 32'h0);
        err_en             = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0200;
        clk_step();
        bus.redirect_valid = 1'b0;
        check("t4_resume_valid", bus.mem_req_valid, 32'h1);
        check("t4_resume_addr", bus.mem_req_addr, 32'h8000_0200);
        expect_out("t4_e3", 32'h8000_0200, 1'b0);

        // Redirect near the top of the address space; low bits ignored.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        clk_step();
        bus.redirect_valid = 1'b0;
        expect_out("t5_top", 32'hFFFF_FFFC, 1'b0);
        expect_out("t5_wrap", 32'h0000_0000, 1'b0);
        check("t5_wrap_req_addr", last_hs_addr, 32'h0000_0004);

        // Memory not ready for 3 cycles: address held, one request issued.
        do_reset();
        bus.mem_req_ready = 1'b0;
        clk_step();
        for (int i = 0; i < 3; i++) begin
            check("t6_stall_valid", bus.mem_req_valid, 32'h1);
            check("t6_stall_addr", bus.mem_req_addr, 32'h8000_0000);
            clk_step();
        end
        check("t6_no_hs_yet", hs_cnt, 32'd0);
        bus.mem_req_ready = 1'b1;
        clk_step();
        bus.mem_req_ready = 1'b0;
        check("t6_single_hs", hs_cnt, 32'd1);
        check("t6_hs_addr", last_hs_addr, 32'h8000_0000);
        expect_out("t6_e0", 32'h8000_0000, 1'b0);
        check("t6_still_single", hs_cnt, 32'd1);
        check("t6_next_addr", bus.mem_req_addr, 32'h8000_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifu_pipe.md
IFU_PIPE -- requirements
Module: ifu_pipe

Interface
REQ-001 Parameter XLEN, default 32: address/PC width.
REQ-002 Parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-003 Parameter FIFO_DEPTH, default 4: instruction buffer entries; power of two, >=2.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 redirect_valid  in  1  flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 mem_req_valid  out  1  fetch request to instruction memory.
REQ-009 mem_req_ready  in  1  memory accepts request.
REQ-010 mem_req_addr  out  XLEN  word-aligned fetch address.
REQ-011 mem_rsp_valid  in  1  response present; no back-pressure, one cycle per response.
REQ-012 mem_rsp_data  in  32  instruction word.
REQ-013 mem_rsp_err  in  1  access fault for this response.
REQ-014 out_valid  out  1  buffered instruction available to decode.
REQ-015 out_ready  in  1  decode consumes head entry.
REQ-016 out_pc / out_inst / out_err  out  XLEN/32/1  head entry fields.

Function
REQ-017 FSM states REQ, WAIT, DROP, HALT; at most one request outstanding.
REQ-018 REQ: mem_req_valid=1 iff buffer count < FIFO_DEPTH; addr = fetch_pc; handshake (valid&ready) -> WAIT, latching req_pc=fetch_pc.
REQ-019 WAIT: on mem_rsp_valid push {req_pc, data, err}; err=0 -> fetch_pc+=4, go REQ; err=1 -> HALT, fetch_pc unchanged.
REQ-020 HALT: no requests; leaves only on redirect.
REQ-021 DROP: next mem_rsp_valid discarded (no push) -> REQ.
REQ-022 Redirect (highest priority): fetch_pc<=redirect_pc&~3; buffer flushed; from WAIT, or from REQ with same-cycle handshake, -> DROP; from DROP stays DROP; from REQ without handshake or HALT -> REQ; response arriving that cycle discarded.
REQ-023 fetch_pc increment wraps modulo 2^XLEN.
REQ-024 Buffer FIFO: out_valid = count!=0; pop on out_valid&out_ready; simultaneous push and pop keeps count; push never occurs when full (guaranteed by REQ-018).
REQ-025 Latency: request accepted cycle N, response cycle M>N -> out_valid earliest cycle M+1.
REQ-026 A pop in the redirect cycle is a valid consumption; flush takes effect the following cycle (out_valid=0).
REQ-027 mem_req_valid held with constant addr until accepted unless redirect occurs.

Reset
REQ-028 rst=0 at posedge: state=REQ, fetch_pc=RESET_PC, buffer empty, out_valid=0, mem_req_valid=0 during reset cycle.
REQ-029 Reset mid-WAIT: pending response after reset release is discarded (state enters DROP only if handshake occurred; otherwise bench must not return stale response -- reset restarts from RESET_PC).
REQ-030 All outputs registered or derived from registered state; out_pc/out_inst/out_err = 0 when empty.

Structure
REQ-031 Shared package ifu_pkg: FSM state enum, default RESET_PC constant, fetch-entry struct {pc, inst, err}.
REQ-032 Buffer implemented as sub-module sync_fifo (parameterised width/depth, flush input).

Verification
REQ-033 Reset release, memory always ready, 1-cycle latency, out_ready=1 -> out_pc sequence 8000_0000, 8000_0004, 8000_0008 with matching data.
REQ-034 out_ready=0 -> exactly 4 entries buffered, mem_req_valid drops to 0; assert out_ready -> requests resume at 8000_0010.
REQ-035 Redirect to 8000_0102 while WAIT -> in-flight response dropped, next request addr 8000_0100, buffer empty next cycle.
REQ-036 mem_rsp_err=1 at 8000_0008 -> entry out_err=1, no further requests; redirect 8000_0200 resumes fetch.
REQ-037 fetch_pc FFFF_FFFC with XLEN=32 -> following request addr 0000_0000.
REQ-038 mem_req_ready low 3 cycles -> addr stable, single request issued.
